// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, default
// timing, and word/byte-lane geometry.
package dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam int DEFAULT_WAIT_CYC = 2;
   localparam int DEFAULT_ADDR_W   = 10;

   localparam int WORD_W    = 32;
   localparam int BYTE_W    = 8;
   localparam int NUM_LANES = WORD_W / BYTE_W;

   // Wide enough for the largest supported wait-state count (15)
   localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage for the responder: single port, per-byte write
// enables, combinational read. Contents have no reset.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_W-1:0]    addr,
   input  logic [WORD_W-1:0]    wdata,
   input  logic [NUM_LANES-1:0] be,
   output logic [WORD_W-1:0]    rdata
);

   logic [WORD_W-1:0] mem [0:(2**ADDR_W)-1];

   // Byte-lane write: only lanes with their enable set are updated
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (be[i]) begin
               mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_CYC
// cycles, then commits the store / samples the load and holds the response
// until the initiator consumes it.
// Optional feature: define DMEM_ERR_CHECK_EN to flag misaligned or
// out-of-range addresses (faulted stores do not write).
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W   = DEFAULT_ADDR_W,
   parameter int WAIT_CYC = DEFAULT_WAIT_CYC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   // First counter value on entering WAIT; WAIT is left when it reaches 0
   localparam logic [CNT_W-1:0] CNT_INIT =
      (WAIT_CYC > 0) ? CNT_W'(WAIT_CYC - 1) : '0;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic [WORD_W-1:0]   wdata_q, wdata_d;
   logic [NUM_LANES-1:0] be_q, be_d;
   logic                fault_q, fault_d;
   logic [WORD_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;

   logic                req_fault;
   logic                is_idle;
   logic                commit;
   logic                cmd_we;
   logic                cmd_fault;
   logic [ADDR_W-1:0]   cmd_waddr;
   logic [WORD_W-1:0]   cmd_wdata;
   logic [NUM_LANES-1:0] cmd_be;
   logic                mem_we;
   logic [WORD_W-1:0]   mem_rdata;

`ifdef DMEM_ERR_CHECK_EN
   assign req_fault = (req_addr[1:0] != 2'b00) ||
                      ((req_addr >> (ADDR_W + 2)) != 32'd0);
`else
   logic unused_addr;
   assign unused_addr = ^req_addr;
   assign req_fault   = 1'b0;
`endif

   // With zero wait states the commit happens on the accepting edge, so the
   // live request inputs are used while idle and the latched copy otherwise.
   assign is_idle   = (state_q == ST_IDLE);
   assign cmd_we    = is_idle ? req_we                  : we_q;
   assign cmd_waddr = is_idle ? req_addr[ADDR_W+1:2]    : waddr_q;
   assign cmd_wdata = is_idle ? req_wdata               : wdata_q;
   assign cmd_be    = is_idle ? req_be                  : be_q;
   assign cmd_fault = is_idle ? req_fault               : fault_q;
   assign mem_we    = commit & cmd_we & ~cmd_fault;

   dmem_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .addr  (cmd_waddr),
      .wdata (cmd_wdata),
      .be    (cmd_be),
      .rdata (mem_rdata)
   );

   // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      fault_d = fault_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      commit  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               waddr_d = req_addr[ADDR_W+1:2];
               wdata_d = req_wdata;
               be_d    = req_be;
               fault_d = req_fault;
               if (WAIT_CYC == 0) begin
                  state_d = ST_RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
               rdata_d = '0;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (commit) begin
         rdata_d = (cmd_we || cmd_fault) ? '0 : mem_rdata;
         err_d   = cmd_fault;
      end
   end

   // State and latched-request registers; reset aborts any in-flight request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         fault_q <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         fault_q <= fault_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign req_ready = is_idle;
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rsp_valid ? rdata_q : '0;
   assign rsp_err   = rsp_valid & err_q;

endmodule
